// File: rtl/aidc_lite_pkg.sv
// Shared definitions for the AIDC-Lite compression datapath.
package aidc_lite_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CONV  = 2'd1,
    S_READY = 2'd2
  } comp_state_t;

  localparam int          AIDC_BLK_ENTRIES = 16;
  localparam int          AIDC_IDX_W       = 4;
  localparam logic [15:0] BF16_QNAN_BIT    = 16'h0040;

endpackage

// File: rtl/aidc_lite_fp32_to_bf16.sv
// FP32 -> BF16 narrowing for one lane. NaNs are forced quiet with their sign
// kept; everything else is either rounded to nearest-even or truncated.
module aidc_lite_fp32_to_bf16
  import aidc_lite_pkg::*;
#(
  parameter int RNE = 1
) (
  input  logic [31:0] fp32,
  output logic [15:0] bf16
);

  // exp all ones with a non-zero mantissa
  function automatic logic is_nan(input logic [31:0] x);
    return (&x[30:23]) && (|x[22:0]);
  endfunction

  // Round-half-even on the dropped 16 bits; a carry out of the mantissa
  // walks into the exponent, so the largest finite value becomes infinity.
  function automatic logic [15:0] round_rne(input logic [31:0] x);
    logic inc;
    inc = x[15] & ((|x[14:0]) | x[16]);
    return x[31:16] + {15'd0, inc};
  endfunction

  logic [15:0] rounded;
  logic [15:0] truncated;
  logic [15:0] quieted;

  assign rounded   = round_rne(fp32);
  assign truncated = fp32[31:16];
  assign quieted   = fp32[31:16] | BF16_QNAN_BIT;

  assign bf16 = is_nan(fp32) ? quieted : ((RNE != 0) ? rounded : truncated);

endmodule

// File: rtl/aidc_lite_bf16_comp.sv
// AIDC-Lite BF16 compression stage: buffers one 128 B FP32 block, narrows it
// to 64 B of BF16 on start, then serves the result through a show-ahead port.
module aidc_lite_bf16_comp
  import aidc_lite_pkg::*;
#(
  parameter int RNE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        buf_wren_i,
  input  logic [3:0]  buf_waddr_i,
  input  logic [7:0]  buf_wbe_i,
  input  logic [63:0] buf_wdata_i,
  input  logic        comp_start_i,
  output logic        comp_ready_o,
  input  logic        comp_rden_i,
  output logic [31:0] comp_rdata_o
);

  logic [63:0] ibuf [AIDC_BLK_ENTRIES];
  logic [31:0] obuf [AIDC_BLK_ENTRIES];

  comp_state_t           state;
  comp_state_t           state_nxt;
  logic [AIDC_IDX_W-1:0] cnt;
  logic [AIDC_IDX_W-1:0] rptr;

  logic        start_acc;
  logic        conv_last;
  logic        pop_acc;
  logic        vld_p0;
  logic [63:0] entry_p0;
  logic [15:0] bf_lo_p0;
  logic [15:0] bf_hi_p0;

  assign start_acc = (state == S_IDLE) && comp_start_i;
  assign conv_last = (state == S_CONV) && (cnt == 4'd15);
  assign pop_acc   = (state == S_READY) && comp_rden_i;

  // Stage p0: current input entry through both lane converters
  assign vld_p0   = (state == S_CONV);
  assign entry_p0 = ibuf[cnt];

  aidc_lite_fp32_to_bf16 #(.RNE(RNE)) u_lane_lo (
    .fp32 (entry_p0[31:0]),
    .bf16 (bf_lo_p0)
  );

  aidc_lite_fp32_to_bf16 #(.RNE(RNE)) u_lane_hi (
    .fp32 (entry_p0[63:32]),
    .bf16 (bf_hi_p0)
  );

  // Input buffer: byte-granular writes, frozen while conversion reads it
  always_ff @(posedge clk) begin
    if (buf_wren_i && (state != S_CONV)) begin
      for (int k = 0; k < 8; k++) begin
        if (buf_wbe_i[k]) begin
          ibuf[buf_waddr_i][8*k +: 8] <= buf_wdata_i[8*k +: 8];
        end
      end
    end
  end

  // Output buffer: the upper (earlier) lane lands in the low half-word
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      obuf[cnt] <= {bf_lo_p0, bf_hi_p0};
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (comp_start_i) state_nxt = S_CONV;
      S_CONV:  if (cnt == 4'd15) state_nxt = S_READY;
      S_READY: if (comp_rden_i && (rptr == 4'd15)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Conversion index: cleared on start, one entry per CONV cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (start_acc) begin
      cnt <= '0;
    end else if (state == S_CONV) begin
      cnt <= cnt + 4'd1;
    end
  end

  // Read pointer: cleared on entering READY, advanced by each accepted pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr <= '0;
    end else if (conv_last) begin
      rptr <= '0;
    end else if (pop_acc) begin
      rptr <= rptr + 4'd1;
    end
  end

  assign comp_ready_o = (state == S_READY);
  assign comp_rdata_o = (state == S_READY) ? obuf[rptr] : 32'd0;

endmodule

// File: doc/aidc_lite_bf16_comp.md
# aidc_lite_bf16_comp

Compression stage that sits directly downstream of the AIDC-Lite compression engine's fetch path.
- Absorbs one 128 B block, as 32 FP32 words, through the 64-bit block-buffer write port.
- On `comp_start_i`, converts each FP32 word to BF16, giving a fixed 2:1 ratio.
- Exposes the 64 B result as 16 × 32-bit words through a show-ahead read port. The engine's write phase drains this port.

## Interface
Parameters:
- `RNE`, default 1: 1 = round-to-nearest-even; 0 = truncate.

Ports:
- `clk`  in  1  clock; all flops rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `buf_wren_i`  in  1  block-buffer write enable.
- `buf_waddr_i`  in  4  input entry index, 0..15.
- `buf_wbe_i`  in  8  byte enables; bit k covers `buf_wdata_i[8k+7:8k]`.
- `buf_wdata_i`  in  64  write data.
- `comp_start_i`  in  1  pulse: block complete, begin conversion.
- `comp_ready_o`  out  1  level: compressed block available.
- `comp_rden_i`  in  1  pop one output word.
- `comp_rdata_o`  out  32  current output word (show-ahead).

## Operation
Storage:
- Input buffer `ibuf`: 16 × 64 b, byte-writable. Not reset.
- Output buffer `obuf`: 16 × 32 b. Not reset.
- `ibuf` writes are accepted in IDLE and READY. They are dropped in CONV.

State machine:
- IDLE
  - On `comp_start_i`: clear `cnt` and go to CONV.
- CONV
  - Every cycle: `obuf[cnt]` ← {`cvt(ibuf[cnt][31:0])`, `cvt(ibuf[cnt][63:32])`}. The upper lane (earlier beat) lands in bits [15:0].
  - `cnt++`.
  - When `cnt`==15: go to READY and clear `rptr`.
- READY
  - `comp_rdata_o` = `obuf[rptr]`.
  - On `comp_rden_i`: `rptr++`.
  - A `comp_rden_i` while `rptr`==15 returns to IDLE.

Conversion `cvt(x)`:
- NaN (exp==0xFF, mantissa≠0): result = `x[31:16] | 16'h0040`, i.e. forced quiet with sign preserved.
- Otherwise, `RNE`=1: result = `x[31:16] + (x[15] & (|x[14:0] | x[16]))`, 16-bit add.
  - Carry into the exponent is legal; finite max rounds to ±Inf.
  - Denormals are preserved, not flushed.
- `RNE`=0: result = `x[31:16]`.

Ignored inputs:
- `comp_start_i` outside IDLE is ignored.
- `comp_rden_i` outside READY is ignored.
- If start and a write are both high in the same IDLE cycle, the write is committed before CONV reads that entry.

`cnt` and `rptr` are 4 bits; wrap at 15 is the exit condition.

## Timing
- Reset values: state IDLE; `cnt`=0; `rptr`=0; `comp_ready_o`=0; `comp_rdata_o`=0.
- `comp_ready_o` is registered, `comp_ready_o` = (state==READY).
  - It rises exactly 16 clocks after the edge that samples `comp_start_i`.
  - It falls on the edge that samples the 16th `comp_rden_i`.
- `comp_rdata_o` is combinational from `obuf[rptr]`, gated to 0 outside READY.
  - Word 0 is valid in the same cycle `comp_ready_o` rises.
  - The next word is valid in the cycle after each sampled `comp_rden_i`.
  - `comp_rden_i` may have arbitrary gaps.
- Throughput: one block per 16 + 16 + (start gap) cycles. No stalls inside CONV.
- Reset mid-CONV or mid-READY:
  - Returns to IDLE immediately; `comp_ready_o` drops asynchronously.
  - The partial output is discarded. Buffer contents are undefined but harmless.

## Structure
- Shared package `aidc_lite_pkg`:
  - state enum `comp_state_t` {S_IDLE, S_CONV, S_READY}.
  - `AIDC_BLK_ENTRIES`=16.
  - `BF16_QNAN_BIT`=16'h0040.
- One sub-module `aidc_lite_fp32_to_bf16`:
  - Pure combinational.
  - Parameter `RNE`.
  - Instantiated twice, once per lane.

## Test plan
1. Basic conversion: write `ibuf[0]` = 64'h3F800000_40490FDB, then start → after 16 clocks `comp_ready_o`=1 and `comp_rdata_o`=32'h40493F80.
2. Rounding, `RNE`=1: 0x3F808000→0x3F80; 0x3F818000→0x3F82; 0x3F808001→0x3F81; 0x7F7FFFFF→0x7F80. With `RNE`=0, all truncate.
3. Specials: 0x7F800001→0x7FC0; 0xFF800000→0xFF80; 0x00000001→0x0000; 0x80018000 (RNE)→0x8002.
4. Handshake: fill 16 entries, start, issue 16 `comp_rden_i` with random gaps → 16 words in `rptr` order. `comp_ready_o` and `comp_rdata_o` reach 0 after the 16th pop. A start pulse issued in READY has no effect.
5. Reset: assert `rst` at CONV cycle 8 → `comp_ready_o` stays 0. A fresh fill and start then produce correct output.
6. System: integrate with the compression engine for `len`=2 blocks on an AHB memory model → the destination holds 2 × 64 B BF16 images matching a software model.
